// File: rtl/out_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : out_ram_reader
// Brief    : Reads all four words of the output RAM in one request cycle,
//            snapshots them, and streams them over valid/ready one per beat.
// Revision : 1.0 - initial release
// ============================================================================
module out_ram_reader #(
  parameter int DW      = 8,
  parameter int AW      = 2,
  parameter int REVERSE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr0,
  output logic [AW-1:0] ram_addr1,
  output logic [AW-1:0] ram_addr2,
  output logic [AW-1:0] ram_addr3,
  input  logic [DW-1:0] ram_data_r0,
  input  logic [DW-1:0] ram_data_r1,
  input  logic [DW-1:0] ram_data_r2,
  input  logic [DW-1:0] ram_data_r3,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_REQ     = 3'd1;
  localparam logic [2:0] c_CAPTURE = 3'd2;
  localparam logic [2:0] c_SEND    = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [1:0]    r_idx;
  logic [DW-1:0] r_buf [4];
  logic          w_xfer;
  logic [1:0]    w_sel;

  // The reader never writes; each read port always fetches its own word.
  assign ram_we    = 1'b0;
  assign ram_addr0 = AW'(0);
  assign ram_addr1 = AW'(1);
  assign ram_addr2 = AW'(2);
  assign ram_addr3 = AW'(3);

  assign w_xfer = (r_state == c_SEND) && out_ready;
  // Reverse order is 3-idx, which for a 2-bit index is its bitwise inverse.
  assign w_sel  = (REVERSE != 0) ? ~r_idx : r_idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start is only looked at while idle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:    if (start) w_next_state = c_REQ;
      c_REQ:     w_next_state = c_CAPTURE;
      c_CAPTURE: w_next_state = c_SEND;
      c_SEND:    if (out_ready && (r_idx == 2'd3)) w_next_state = c_DONE;
      c_DONE:    w_next_state = c_IDLE;
      default:   w_next_state = c_IDLE;
    endcase
  end

  // Snapshot buffer and word index; buffer only loads during CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      if (r_state == c_CAPTURE) begin
        r_buf[0] <= ram_data_r0;
        r_buf[1] <= ram_data_r1;
        r_buf[2] <= ram_data_r2;
        r_buf[3] <= ram_data_r3;
      end
      if (w_xfer) r_idx <= r_idx + 2'd1;
    end
  end

  // Output decode from state; data is zero whenever not presenting a word
  always_comb begin
    ram_ce    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (r_state != c_IDLE);
    done      = 1'b0;
    case (r_state)
      c_REQ:  ram_ce = 1'b1;
      c_SEND: begin
        out_valid = 1'b1;
        out_last  = (r_idx == 2'd3);
        out_data  = r_buf[w_sel];
      end
      c_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_out_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_ram_reader
// Brief    : Scoreboard bench; two instances (forward and reversed order)
//            share one RAM model and one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_ram_reader;
  localparam int DW = 8;
  localparam int AW = 2;

  // Expected per-cycle profile of a drain with ready held high (bit r = cycle r)
  localparam logic [7:0] T_CE    = 8'b0000_0001;
  localparam logic [7:0] T_VALID = 8'b0011_1100;
  localparam logic [7:0] T_LAST  = 8'b0010_0000;
  localparam logic [7:0] T_DONE  = 8'b0100_0000;
  localparam logic [7:0] T_BUSY  = 8'b0111_1111;

  logic clk;
  logic rst_n;
  logic start;
  logic out_ready;

  logic [DW-1:0] mem [4];
  logic [AW-1:0] a0 [4];
  logic [AW-1:0] a1 [4];
  logic [AW-1:0] aq0 [4];
  logic [AW-1:0] aq1 [4];
  logic [DW-1:0] rd0 [4];
  logic [DW-1:0] rd1 [4];
  logic          ce [2];
  logic          we [2];
  logic          ov [2];
  logic          ol [2];
  logic          bz [2];
  logic          dn [2];
  logic [DW-1:0] od [2];

  int checks = 0;
  int errors = 0;
  int exp_ce = 0;
  int ce_cnt [2];
  int mode = 0;
  int pidx = 0;
  logic pat [$];

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic       held [2];
  logic [8:0] held_v [2];
  logic       dexp [2];

  out_ram_reader #(.DW(DW), .AW(AW), .REVERSE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_ce(ce[0]), .ram_we(we[0]),
    .ram_addr0(a0[0]), .ram_addr1(a0[1]), .ram_addr2(a0[2]), .ram_addr3(a0[3]),
    .ram_data_r0(rd0[0]), .ram_data_r1(rd0[1]), .ram_data_r2(rd0[2]), .ram_data_r3(rd0[3]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_last(ol[0]),
    .busy(bz[0]), .done(dn[0])
  );

  out_ram_reader #(.DW(DW), .AW(AW), .REVERSE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_ce(ce[1]), .ram_we(we[1]),
    .ram_addr0(a1[0]), .ram_addr1(a1[1]), .ram_addr2(a1[2]), .ram_addr3(a1[3]),
    .ram_data_r0(rd1[0]), .ram_data_r1(rd1[1]), .ram_data_r2(rd1[2]), .ram_data_r3(rd1[3]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_last(ol[1]),
    .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address registered on ce, data read live from the array so
  // later writes show up on the read ports (exposes a missing snapshot)
  always @(posedge clk) begin
    if (ce[0]) for (int k = 0; k < 4; k++) aq0[k] <= a0[k];
    if (ce[1]) for (int k = 0; k < 4; k++) aq1[k] <= a1[k];
  end
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd0[k] = mem[aq0[k]];
      rd1[k] = mem[aq1[k]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ready driver
  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pidx % pat.size()]; pidx++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops on each handshake, checks hold-while-stalled and done timing
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin held[d] = 1'b0; dexp[d] = 1'b0; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (dn[d] || dexp[d]) chk("done_pulse", 32'(dn[d]), 32'(dexp[d]));
        dexp[d] = 1'b0;
        if (ce[d]) begin
          ce_cnt[d]++;
          chk("ram_we", 32'(we[d]), 32'd0);
        end
        if (ov[d]) begin
          if (held[d]) chk("hold_stable", 32'({ol[d], od[d]}), 32'(held_v[d]));
          if (out_ready) begin
            held[d] = 1'b0;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL extra_word dut%0d actual=%0h required=none", d, od[d]);
            end else begin
              if (d == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk(d == 0 ? "word_fwd" : "word_rev", 32'({ol[d], od[d]}), 32'(e));
              dexp[d] = e[8];
            end
          end else begin
            held[d]   = 1'b1;
            held_v[d] = {ol[d], od[d]};
          end
        end else begin
          if (held[d]) chk("valid_dropped_in_stall", 32'(ov[d]), 32'd1);
          held[d] = 1'b0;
          if (ol[d]) chk("last_without_valid", 32'(ol[d]), 32'd0);
        end
      end
    end
  end

  // Reference model: one drain delivers the four RAM words as they stand when
  // the drain is requested, in address order (forward) or reverse order.
  task automatic push_exp();
    for (int k = 0; k < 4; k++) begin
      q0.push_back({1'(k == 3), mem[k]});
      q1.push_back({1'(k == 3), mem[3-k]});
    end
    exp_ce++;
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1; push_exp();
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bz[0] !== 1'b0 || bz[1] !== 1'b0) begin
      @(posedge clk); #2;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
  endtask

  task automatic end_checks(input string nm);
    @(negedge clk);
    chk({nm, "_q_fwd_empty"}, 32'(q0.size()), 32'd0);
    chk({nm, "_q_rev_empty"}, 32'(q1.size()), 32'd0);
    chk({nm, "_ce_count_fwd"}, 32'(ce_cnt[0]), 32'(exp_ce));
    chk({nm, "_ce_count_rev"}, 32'(ce_cnt[1]), 32'(exp_ce));
  endtask

  task automatic load(input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [7:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ce_cnt[0] = 0; ce_cnt[1] = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0;
    start = 1'b0;
    load(8'h11, 8'h22, 8'h33, 8'h44);

    // Reset values
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ce", 32'(ce[d]), 32'd0);
      chk("rst_valid", 32'(ov[d]), 32'd0);
      chk("rst_last", 32'(ol[d]), 32'd0);
      chk("rst_data", 32'(od[d]), 32'd0);
      chk("rst_busy", 32'(bz[d]), 32'd0);
      chk("rst_done", 32'(dn[d]), 32'd0);
    end
    chk("addr_ports", 32'({a0[3], a0[2], a0[1], a0[0]}), 32'h0000_00E4);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1) Cycle-exact drain with ready held high
    @(posedge clk); #1 start = 1'b1; push_exp();
    @(posedge clk);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if (r == 0) start = 1'b0;
      chk("t1_ce", 32'(ce[0]), 32'(T_CE[r]));
      chk("t1_valid", 32'(ov[0]), 32'(T_VALID[r]));
      chk("t1_done", 32'(dn[0]), 32'(T_DONE[r]));
      chk("t1_busy", 32'(bz[0]), 32'(T_BUSY[r]));
      if (T_VALID[r]) begin
        chk("t1_data", 32'(od[0]), 32'(mem[r-2]));
        chk("t1_last", 32'(ol[0]), 32'(T_LAST[r]));
      end
    end
    end_checks("t1");

    // 2) Stalling consumer
    mode = 1; pidx = 0;
    kick(); wait_idle(); end_checks("t2");
    mode = 0;

    // 3) Reverse ordering
    load(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    kick(); wait_idle(); end_checks("t3");

    // 4) Snapshot: overwrite word0 once the buffer has been captured
    load(8'h11, 8'h22, 8'h33, 8'h44);
    kick();
    @(posedge clk); @(posedge clk); #1 mem[0] = 8'hFF;
    wait_idle(); end_checks("t4a");
    kick(); wait_idle(); end_checks("t4b");

    // 5a) start pulsed mid-drain is ignored
    kick();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(); end_checks("t5a");

    // 5b) start held high: two back-to-back drains
    @(posedge clk); #1 start = 1'b1; push_exp(); push_exp();
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    chk("t5b_second_req", 32'(ce[0]), 32'd1);
    wait_idle(); end_checks("t5b");

    // 6) Reset during SEND after two transfers
    load(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    kick();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(ov[0]), 32'd0);
    chk("t6_busy_async", 32'(bz[0]), 32'd0);
    chk("t6_done_async", 32'(dn[0]), 32'd0);
    exp_ce = ce_cnt[0];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    kick(); wait_idle(); end_checks("t6");

    // Randomized drains with a random consumer and stray starts
    mode = 2;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      kick();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_idle();
      end_checks("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
